fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the next-generation pipelined CPU. It replaces the bare PC register and single FI_ID latch with a PC generator, a one-cycle synchronous imem request interface and a DEPTH-entry prefetch FIFO. Decode can stall without losing fetched instructions. Taken branches or jumps from ID flush all queued and in-flight fetches.

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_unit_sync_fifo.sv | 56 +++++
 rtl/fetch_unit.sv | 84 ++++++++
 tb/tb_fetch_unit.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage constants and the control-transfer encoding used by ID.
package fetch_unit_pkg;

    localparam int PC_STEP          = 4;
    localparam int RESET_PC_DEFAULT = 0;

    // ID's control-transfer kind; anything other than CB_NONE drives redirect.
    typedef enum logic [1:0] {
        CB_NONE   = 2'b00,
        CB_BRANCH = 2'b01,
        CB_JUMP   = 2'b10,
        CB_JALR   = 2'b11
    } cb_e;

    function automatic logic cb_redirects(input cb_e cb);
        return cb != CB_NONE;
    endfunction

endpackage

// File: rtl/fetch_unit_sync_fifo.sv
// Prefetch queue: DEPTH entries, combinational head read, flush discards all entries.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    // A push into a full queue is only legal when the head leaves the same cycle.
    assign do_push = push & (~full | pop) & ~flush;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy tracking; flush empties by catching rd_ptr up to wr_ptr.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents need no reset since empty entries are never shown.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC generator, one-cycle imem request, prefetch queue.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [ADDR_W-1:0]      imem_addr,
    input  logic [DATA_W-1:0]      imem_rdata,
    input  logic                   redirect,
    input  logic [ADDR_W-1:0]      redirect_pc,
    input  logic                   pause,
    output logic                   inst_valid,
    output logic [DATA_W-1:0]      inst,
    output logic [ADDR_W-1:0]      inst_pc,
    output logic [$clog2(DEPTH):0] fifo_cnt
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = ADDR_W + DATA_W;

    logic [ADDR_W-1:0] pc, inflight_pc;
    logic              inflight;
    logic              pop, push, empty, full;
    logic [CW:0]       occ;
    logic [EW-1:0]     head, last;

    assign pop  = inst_valid & ~pause;
    // The in-flight response is dropped whenever ID redirects in its arrival cycle.
    assign push = inflight & ~redirect;
    // Slots already promised (queued + in flight) minus the one leaving this cycle.
    assign occ  = {1'b0, fifo_cnt} + (CW+1)'(inflight) - (CW+1)'(pop);

    assign imem_req   = rst & ~redirect & (occ < (CW+1)'(DEPTH));
    assign imem_addr  = pc;
    assign inst_valid = ~empty;

    // PC and in-flight tracking; redirect beats sequential fetch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            if (redirect)      pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
            else if (imem_req) pc <= pc + ADDR_W'(PC_STEP);
            inflight <= imem_req;
            if (imem_req) inflight_pc <= pc;
        end
    end

    // Remember the last presented head so inst/inst_pc stay put while the queue is empty.
    always_ff @(posedge clk) begin
        if (!rst)            last <= '0;
        else if (inst_valid) last <= head;
    end

    // Present the head when valid, otherwise the held copy.
    always_comb begin
        {inst_pc, inst} = last;
        if (inst_valid) {inst_pc, inst} = head;
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   ({inflight_pc, imem_rdata}),
        .dout  (head),
        .count (fifo_cnt),
        .empty (empty),
        .full  (full)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;
    localparam int AW = 32, DW = 32, DEPTH = 4, CW = 3;

    logic          clk = 1'b0, rst = 1'b0, redirect = 1'b0, pause = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic [DW-1:0] imem_rdata  = '0;
    logic          imem_req, inst_valid;
    logic [AW-1:0] imem_addr, inst_pc;
    logic [DW-1:0] inst;
    logic [CW-1:0] fifo_cnt;

    int tests = 0, fails = 0;

    // Reference model: fetch stream as a queue of PCs plus at most one outstanding request.
    logic [AW-1:0] m_pc, m_fly_pc, m_last_pc;
    logic [DW-1:0] m_last_inst;
    logic          m_fly;
    logic [AW-1:0] m_q[$];
    logic          e_req, e_valid;
    logic [AW-1:0] e_addr, e_pc;
    logic [DW-1:0] e_inst;
    logic [CW-1:0] e_cnt;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
        .pause(pause), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .fifo_cnt(fifo_cnt)
    );

    // Instruction memory contents: a scramble of the address so data/PC pairing is checked.
    function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    task automatic model_exp();
        int pop;
        pop     = (m_q.size() > 0 && !pause) ? 1 : 0;
        e_valid = m_q.size() > 0;
        e_pc    = m_last_pc;
        e_inst  = m_last_inst;
        if (m_q.size() > 0) begin
            e_pc   = m_q[0];
            e_inst = word_at(m_q[0]);
        end
        e_cnt  = CW'(m_q.size());
        e_req  = rst && !redirect && (m_q.size() + int'(m_fly) - pop < DEPTH);
        e_addr = m_pc;
    endtask

    // Advance model and DUT by one clock; imem answers one cycle after each request.
    task automatic tick();
        logic          r;
        logic [AW-1:0] a;
        model_exp();
        r = imem_req;
        a = imem_addr;
        if (!rst) begin
            m_pc = '0; m_fly = 1'b0; m_q.delete(); m_last_pc = '0; m_last_inst = '0;
        end else begin
            if (m_q.size() > 0) begin
                m_last_pc   = m_q[0];
                m_last_inst = word_at(m_q[0]);
            end
            if (redirect) begin
                m_q.delete();
                m_fly = 1'b0;
                m_pc  = {redirect_pc[AW-1:2], 2'b00};
            end else begin
                if (m_q.size() > 0 && !pause) void'(m_q.pop_front());
                if (m_fly) m_q.push_back(m_fly_pc);
                m_fly = e_req;
                if (e_req) begin
                    m_fly_pc = m_pc;
                    m_pc     = m_pc + 32'd4;
                end
            end
        end
        @(posedge clk);
        #1 imem_rdata = r ? word_at(a) : $urandom;
        @(negedge clk);
    endtask

    task automatic fill_to_three(input string name);
        int n;
        rst = 1'b0; redirect = 1'b0; pause = 1'b0; tick();
        rst = 1'b1; pause = 1'b1;
        n = 0;
        while (!(m_q.size() == 3 && m_fly) && n < 20) begin
            #1 model_exp(); tests++;
            if ({imem_req,imem_addr,inst_valid,inst,inst_pc,fifo_cnt} !== {e_req,e_addr,e_valid,e_inst,e_pc,e_cnt}) begin
                fails++; $display("FAIL %s_fill @%0t got %h want %h", name, $time,
                    {imem_req,imem_addr,inst_valid,inst,inst_pc,fifo_cnt}, {e_req,e_addr,e_valid,e_inst,e_pc,e_cnt});
            end
            tick(); n++;
        end
        tests++;
        if (n >= 20) begin fails++; $display("FAIL %s_fill_timeout got %0d cycles want <20", name, n); end
    endtask

    task automatic test_reset();
        rst = 1'b0; tick(); tick();
        #1 tests++;
        if ({imem_req,inst_valid,inst,inst_pc,fifo_cnt} !== '0) begin
            fails++; $display("FAIL reset_outputs got req=%b v=%b inst=%h pc=%h cnt=%0d want all 0",
                imem_req, inst_valid, inst, inst_pc, fifo_cnt);
        end
    endtask

    task automatic test_stream();
        int first_req = -1, first_v = -1;
        rst = 1'b1; pause = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1 model_exp(); tests++;
            if ({imem_req,imem_addr,inst_valid,inst,inst_pc,fifo_cnt} !== {e_req,e_addr,e_valid,e_inst,e_pc,e_cnt}) begin
                fails++; $display("FAIL stream @%0t got %h want %h", $time,
                    {imem_req,imem_addr,inst_valid,inst,inst_pc,fifo_cnt}, {e_req,e_addr,e_valid,e_inst,e_pc,e_cnt});
            end
            if (imem_req && first_req < 0) first_req = i;
            if (inst_valid && first_v < 0) first_v = i;
            tick();
        end
        tests++;
        if (first_req !== 0 || first_v !== 2) begin
            fails++; $display("FAIL stream_latency got req@%0d valid@%0d want req@0 valid@2", first_req, first_v);
        end
    endtask

    task automatic test_stall_fill();
        logic [AW-1:0] want = 32'h0;
        rst = 1'b0; tick();
        rst = 1'b1; pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1 model_exp(); tests++;
            if ({imem_req,imem_addr,inst_valid,inst,inst_pc,fifo_cnt} !== {e_req,e_addr,e_valid,e_inst,e_pc,e_cnt}) begin
                fails++; $display("FAIL stall @%0t got %h want %h", $time,
                    {imem_req,imem_addr,inst_valid,inst,inst_pc,fifo_cnt}, {e_req,e_addr,e_valid,e_inst,e_pc,e_cnt});
            end
            tick();
        end
        #1 tests++;
        if (fifo_cnt !== 3'd4 || imem_req !== 1'b0 || inst_pc !== 32'h0) begin
            fails++; $display("FAIL stall_full got cnt=%0d req=%b pc=%h want cnt=4 req=0 pc=0", fifo_cnt, imem_req, inst_pc);
        end
        pause = 1'b0;
        #1 tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
            fails++; $display("FAIL stall_restart got req=%b addr=%h want req=1 addr=10", imem_req, imem_addr);
        end
        for (int i = 0; i < 8; i++) begin
            #1 model_exp(); tests++;
            if ({imem_req,imem_addr,inst_valid,inst,inst_pc,fifo_cnt} !== {e_req,e_addr,e_valid,e_inst,e_pc,e_cnt}) begin
                fails++; $display("FAIL drain @%0t got %h want %h", $time,
                    {imem_req,imem_addr,inst_valid,inst,inst_pc,fifo_cnt}, {e_req,e_addr,e_valid,e_inst,e_pc,e_cnt});
            end
            if (inst_valid) begin
                tests++;
                if (inst_pc !== want) begin fails++; $display("FAIL drain_order got %h want %h", inst_pc, want); end
                want = want + 32'd4;
            end
            tick();
        end
    endtask

    task automatic test_redirect_inflight();
        fill_to_three("redir");
        redirect = 1'b1; redirect_pc = 32'h100; pause = 1'b0;
        #1 tests++;
        if (imem_req !== 1'b0) begin fails++; $display("FAIL redir_req got %b want 0", imem_req); end
        tick();
        redirect = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1 model_exp(); tests++;
            if ({imem_req,imem_addr,inst_valid,inst,inst_pc,fifo_cnt} !== {e_req,e_addr,e_valid,e_inst,e_pc,e_cnt}) begin
                fails++; $display("FAIL redir @%0t got %h want %h", $time,
                    {imem_req,imem_addr,inst_valid,inst,inst_pc,fifo_cnt}, {e_req,e_addr,e_valid,e_inst,e_pc,e_cnt});
            end
            if (k == 0) begin
                tests++;
                if (fifo_cnt !== 3'd0 || inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
                    fails++; $display("FAIL redir_flush got cnt=%0d v=%b req=%b addr=%h want 0 0 1 100",
                        fifo_cnt, inst_valid, imem_req, imem_addr);
                end
            end
            if (k == 2) begin
                tests++;
                if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst !== word_at(32'h100)) begin
                    fails++; $display("FAIL redir_target got v=%b pc=%h inst=%h want v=1 pc=100", inst_valid, inst_pc, inst);
                end
            end
            tick();
        end
    endtask

    task automatic test_redirect_pause();
        pause = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        redirect = 1'b1; redirect_pc = 32'h203;
        tick();
        redirect = 1'b0; pause = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1 model_exp(); tests++;
            if ({imem_req,imem_addr,inst_valid,inst,inst_pc,fifo_cnt} !== {e_req,e_addr,e_valid,e_inst,e_pc,e_cnt}) begin
                fails++; $display("FAIL redir_pause @%0t got %h want %h", $time,
                    {imem_req,imem_addr,inst_valid,inst,inst_pc,fifo_cnt}, {e_req,e_addr,e_valid,e_inst,e_pc,e_cnt});
            end
            if (k == 0) begin
                tests++;
                if (imem_addr !== 32'h200 || fifo_cnt !== 3'd0) begin
                    fails++; $display("FAIL redir_align got addr=%h cnt=%0d want addr=200 cnt=0", imem_addr, fifo_cnt);
                end
            end
            if (k == 2) begin
                tests++;
                if (inst_valid !== 1'b1 || inst_pc !== 32'h200) begin
                    fails++; $display("FAIL redir_pause_first got v=%b pc=%h want v=1 pc=200", inst_valid, inst_pc);
                end
            end
            tick();
        end
    endtask

    task automatic test_toggle();
        logic [AW-1:0] prev = '0;
        logic          have = 1'b0;
        rst = 1'b0; tick();
        rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            pause = i[0];
            #1 model_exp(); tests++;
            if ({imem_req,imem_addr,inst_valid,inst,inst_pc,fifo_cnt} !== {e_req,e_addr,e_valid,e_inst,e_pc,e_cnt}) begin
                fails++; $display("FAIL toggle @%0t got %h want %h", $time,
                    {imem_req,imem_addr,inst_valid,inst,inst_pc,fifo_cnt}, {e_req,e_addr,e_valid,e_inst,e_pc,e_cnt});
            end
            tests++;
            if (fifo_cnt > 3'd4) begin fails++; $display("FAIL toggle_cap got %0d want <=4", fifo_cnt); end
            if (inst_valid && !pause) begin
                if (have) begin
                    tests++;
                    if (inst_pc !== prev + 32'd4) begin
                        fails++; $display("FAIL toggle_seq got %h want %h", inst_pc, prev + 32'd4);
                    end
                end
                prev = inst_pc; have = 1'b1;
            end
            tick();
        end
        pause = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst         = ($urandom_range(0, 59) != 0);
            redirect    = ($urandom_range(0, 9) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hffff_fff4 : $urandom;
            pause       = ($urandom_range(0, 2) == 0);
            #1 model_exp(); tests++;
            if ({imem_req,imem_addr,inst_valid,inst,inst_pc,fifo_cnt} !== {e_req,e_addr,e_valid,e_inst,e_pc,e_cnt}) begin
                fails++; $display("FAIL random @%0t got %h want %h", $time,
                    {imem_req,imem_addr,inst_valid,inst,inst_pc,fifo_cnt}, {e_req,e_addr,e_valid,e_inst,e_pc,e_cnt});
            end
            tick();
        end
        redirect = 1'b0; pause = 1'b0; rst = 1'b1;
    endtask

    task automatic test_reset_mid();
        fill_to_three("rstmid");
        rst = 1'b0; redirect = 1'b1; redirect_pc = 32'h300;
        tick();
        rst = 1'b1; redirect = 1'b0; pause = 1'b1;
        #1 tests++;
        if ({inst_valid,inst,inst_pc,fifo_cnt} !== '0 || imem_addr !== 32'h0 || imem_req !== 1'b1) begin
            fails++; $display("FAIL rstmid_state got v=%b inst=%h pc=%h cnt=%0d addr=%h req=%b want zeros addr=0 req=1",
                inst_valid, inst, inst_pc, fifo_cnt, imem_addr, imem_req);
        end
        tick();
        #1 tests++;
        if (fifo_cnt !== 3'd0 || inst_valid !== 1'b0) begin
            fails++; $display("FAIL rstmid_nopush got cnt=%0d v=%b want 0 0", fifo_cnt, inst_valid);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_stream();
        test_stall_fill();
        test_redirect_inflight();
        test_redirect_pause();
        test_toggle();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
